alu_wide_op_sequencer: RTL
==========================

# alu_wide_op_sequencer

Multi-cycle controller that runs 32-bit operations on the shared 16-bit ArithmeticLogicUnit. It accepts one request over a valid/ready handshake and drives the ALU's A, B, FunSel and WF ports for one to four 16-bit passes. It captures the combinational ALUOut after each pass and returns a 32-bit result with its own Z/C/N/O flags. It is the ALU's only master when wide ops are enabled.

## Interface
- WIDTH, 32: request operand/result width; fixed at 2 × ALU width (16).
- Clock  in  1  rising-edge clock shared with the ALU.
- Reset  in  1  asynchronous, active-low reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  high only in IDLE.
- ReqOp  in  3  000 ADD32, 001 SUB32, 010 AND32, 011 OR32, 100 XOR32, 101 LSL32, 110 LSR32, 111 reserved.
- ReqA, ReqB  in  32  operands (ReqB ignored for shifts).
- Done  out  1  one-cycle result strobe.
- Result  out  32  valid while Done=1; held until the next Done.
- FlagsOut  out  4  {Z,C,N,O} at bits [3:0]; valid with Done.
- Error  out  1  high with Done for reserved op.
- AluA, AluB  out  16  ALU operand drive.
- AluFunSel  out  5  ALU function select (16-bit codes only).
- AluWF  out  1  high in every pass cycle, else 0.
- AluOut  in  16  ALU combinational result.

## Operation
- States: IDLE, PASS1, PASS2, PASS3, PASS4, DONE. Accept on ReqValid&&ReqReady; latch op/operands; go to PASS1, or DONE for a reserved op.
- Each pass drives the ALU for exactly one cycle. AluOut is captured into res_lo/res_hi at the closing edge.
- Skipped passes are bypassed; there is no idle cycle.
- FunSel codes used: ADD 10100, AND 10111, OR 11000, XOR 11001, LSL 11011, LSR 11100, idle 10000.
- ADD32 passes:
  - P1: ADD(A_lo,B_lo). c_lo = res_lo < A_lo (unsigned, sequencer-computed).
  - P2: ADD(A_hi,B_hi).
  - P3: only if c_lo, ADD(res_hi,0x0001).
- SUB32 (A + ~B + 1) passes:
  - P1: ADD(A_lo,~B_lo).
  - P2: always, ADD(res_lo,1).
  - P3: ADD(A_hi,~B_hi).
  - P4: only if either low carry, ADD(res_hi,1).
- AND/OR/XOR32: P1 low half, P2 high half.
- LSL32 passes:
  - P1: LSL(A_lo).
  - P2: LSL(A_hi).
  - P3: only if A[15], OR(res_hi,0x0001).
- LSR32 passes:
  - P1: LSR(A_hi).
  - P2: LSR(A_lo).
  - P3: only if A[16], OR(res_lo,0x8000).
- Carries are computed by the sequencer from the captured values. The ALU's FlagsOut is never read.
- Flags:
  - Z = Result==0.
  - N = Result[31].
  - C: ADD, carry out of bit 31. SUB, carry out (1 = no borrow). LSL, A[31]. LSR, A[0]. Logic ops, 0.
  - O: ADD, A31==B31 && R31!=A31. SUB, A31!=B31 && R31!=A31. Otherwise 0.
- Reserved op: Result=0, FlagsOut=0, Error=1, no pass, AluWF stays 0.

## Timing
- Reset values: state IDLE, ReqReady 1, Done 0, Result 0, FlagsOut 0, Error 0, AluA 0, AluB 0, AluFunSel 10000, AluWF 0.
- Latency: with N passes (1–4), Done is high in cycle N+1 after the accepting edge. Reserved op: Done is high in cycle 1.
- ReqReady is 0 from the accepting edge through DONE. The next accept happens earliest in the cycle after DONE. ReqValid held high therefore gives one op every N+2 cycles.
- ALU outputs are registered (no combinational path from Req* to Alu*). Idle cycles drive FunSel 10000 with WF=0.
- Reset asserted mid-operation: immediate return to reset values. The in-flight op is dropped and no Done is issued.
- Request inputs may change freely while busy; they are ignored.

## Structure
- Package alu_seq_pkg holds:
  - op code localparams;
  - 16-bit FunSel constants;
  - state enum;
  - flag bit indices Z=3, C=2, N=1, O=0.
- One combinational sub-module, alu_seq_flags: computes Z/C/N/O from the operands, result, op and carries.
- The pass table is a case on (op, state) inside the FSM.

## Test plan
- ADD32 0x0000FFFF+0x00000001 -> 3 passes, Result 0x00010000, Flags 0000, Done 4 cycles after accept.
- SUB32 0x00000000-0x00000001 -> Result 0xFFFFFFFF, Z0 C0 N1 O0; SUB32 5-5 -> 0x00000000, Z1 C1.
- LSL32 0x80008000 -> Result 0x00010000, C1; LSR32 0x00010001 -> Result 0x00008000, C1.
- XOR32 0xFFFF0000^0xFFFF0000 -> 2 passes, Result 0, Z1; AluWF high exactly 2 cycles.
- Reserved op 111 -> Done 1 cycle after accept, Error 1, Result 0, AluWF never high.
- Reset low during PASS2 of an ADD -> no Done, outputs at reset values. Then ADD32 0x7FFFFFFF+1 -> Result 0x80000000, N1 O1 C0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared constants for the wide-op sequencer: op codes, 16-bit ALU function
// selects, the sequencer state set and the flag bit positions.
package alu_seq_pkg;

  localparam int ALU_W = 16;
  localparam int WIDTH = 2 * ALU_W;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_LSL  = 3'b101;
  localparam logic [2:0] OP_LSR  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  localparam logic [4:0] FS_IDLE = 5'b10000;
  localparam logic [4:0] FS_ADD  = 5'b10100;
  localparam logic [4:0] FS_AND  = 5'b10111;
  localparam logic [4:0] FS_OR   = 5'b11000;
  localparam logic [4:0] FS_XOR  = 5'b11001;
  localparam logic [4:0] FS_LSL  = 5'b11011;
  localparam logic [4:0] FS_LSR  = 5'b11100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PASS1,
    ST_PASS2,
    ST_PASS3,
    ST_PASS4,
    ST_DONE
  } seq_state_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

  function automatic logic [4:0] logic_funsel(input logic [2:0] op);
    case (op)
      OP_AND:  return FS_AND;
      OP_OR:   return FS_OR;
      default: return FS_XOR;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_flags.sv
// Z/C/N/O for a finished wide op, derived from operand signs, the assembled
// result and the carry the sequencer accumulated across passes.
module alu_seq_flags
  import alu_seq_pkg::*;
(
  input  logic [2:0]       op,
  input  logic             a_msb,
  input  logic             a_lsb,
  input  logic             b_msb,
  input  logic [WIDTH-1:0] result,
  input  logic             carry,
  output logic [3:0]       flags
);

  always_comb begin
    flags = '0;
    if (op != OP_RSVD) begin
      flags[FLAG_Z] = (result == '0);
      flags[FLAG_N] = result[WIDTH-1];
      case (op)
        OP_ADD: begin
          flags[FLAG_C] = carry;
          flags[FLAG_O] = (a_msb == b_msb) && (result[WIDTH-1] != a_msb);
        end
        OP_SUB: begin
          flags[FLAG_C] = carry;
          flags[FLAG_O] = (a_msb != b_msb) && (result[WIDTH-1] != a_msb);
        end
        OP_LSL:  flags[FLAG_C] = a_msb;
        OP_LSR:  flags[FLAG_C] = a_lsb;
        default: flags[FLAG_C] = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/alu_wide_op_sequencer.sv
// Runs one 32-bit request as up to four registered 16-bit passes on the shared
// ALU, capturing AluOut at the end of each pass and strobing Done with the result.
module alu_wide_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [2:0]       ReqOp,
  input  logic [WIDTH-1:0] ReqA,
  input  logic [WIDTH-1:0] ReqB,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       FlagsOut,
  output logic             Error,
  output logic [ALU_W-1:0] AluA,
  output logic [ALU_W-1:0] AluB,
  output logic [4:0]       AluFunSel,
  output logic             AluWF,
  input  logic [ALU_W-1:0] AluOut
);

  seq_state_e       state, state_n;
  logic [2:0]       op_q, op_n;
  logic [WIDTH-1:0] a_q, b_q, a_src, b_src;
  logic [ALU_W-1:0] res_lo, res_hi, res_lo_n, res_hi_n;
  logic             c_lo, c_hi, c_lo_n, c_hi_n;
  logic [ALU_W-1:0] alu_a_n, alu_b_n;
  logic [4:0]       fun_n;
  logic             wf_n;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q, flags_w;
  logic             error_q;
  logic             accept, finish_pass;

  assign accept      = (state == ST_IDLE) && ReqValid;
  assign finish_pass = (state != ST_IDLE) && (state != ST_DONE) && (state_n == ST_DONE);

  // Operands come straight from the request on the accepting edge so pass 1 is
  // already driven in the first cycle after accept.
  assign a_src = (state == ST_IDLE) ? ReqA  : a_q;
  assign b_src = (state == ST_IDLE) ? ReqB  : b_q;
  assign op_n  = (state == ST_IDLE) ? ReqOp : op_q;

  // Capture the pass that is closing and pick the next pass; carries are
  // unsigned wrap checks on the captured sums.
  always_comb begin
    state_n  = state;
    res_lo_n = res_lo;
    res_hi_n = res_hi;
    c_lo_n   = c_lo;
    c_hi_n   = c_hi;
    if (state == ST_IDLE) begin
      if (ReqValid) begin
        state_n  = (ReqOp == OP_RSVD) ? ST_DONE : ST_PASS1;
        res_lo_n = '0;
        res_hi_n = '0;
        c_lo_n   = 1'b0;
        c_hi_n   = 1'b0;
      end
    end else if (state == ST_DONE) begin
      state_n = ST_IDLE;
    end else begin
      case ({op_q, state})
        {OP_ADD, ST_PASS1}: begin
          res_lo_n = AluOut; c_lo_n = AluOut < a_q[ALU_W-1:0]; state_n = ST_PASS2;
        end
        {OP_ADD, ST_PASS2}: begin
          res_hi_n = AluOut; c_hi_n = AluOut < a_q[WIDTH-1:ALU_W];
          state_n  = c_lo ? ST_PASS3 : ST_DONE;
        end
        {OP_ADD, ST_PASS3}: begin
          res_hi_n = AluOut; c_hi_n = c_hi | (AluOut < res_hi); state_n = ST_DONE;
        end
        {OP_SUB, ST_PASS1}: begin
          res_lo_n = AluOut; c_lo_n = AluOut < a_q[ALU_W-1:0]; state_n = ST_PASS2;
        end
        {OP_SUB, ST_PASS2}: begin
          res_lo_n = AluOut; c_lo_n = c_lo | (AluOut < res_lo); state_n = ST_PASS3;
        end
        {OP_SUB, ST_PASS3}: begin
          res_hi_n = AluOut; c_hi_n = AluOut < a_q[WIDTH-1:ALU_W];
          state_n  = c_lo ? ST_PASS4 : ST_DONE;
        end
        {OP_SUB, ST_PASS4}: begin
          res_hi_n = AluOut; c_hi_n = c_hi | (AluOut < res_hi); state_n = ST_DONE;
        end
        {OP_AND, ST_PASS1}, {OP_OR, ST_PASS1}, {OP_XOR, ST_PASS1}: begin
          res_lo_n = AluOut; state_n = ST_PASS2;
        end
        {OP_AND, ST_PASS2}, {OP_OR, ST_PASS2}, {OP_XOR, ST_PASS2}: begin
          res_hi_n = AluOut; state_n = ST_DONE;
        end
        {OP_LSL, ST_PASS1}: begin res_lo_n = AluOut; state_n = ST_PASS2; end
        {OP_LSL, ST_PASS2}: begin
          res_hi_n = AluOut; state_n = a_q[ALU_W-1] ? ST_PASS3 : ST_DONE;
        end
        {OP_LSL, ST_PASS3}: begin res_hi_n = AluOut; state_n = ST_DONE; end
        {OP_LSR, ST_PASS1}: begin res_hi_n = AluOut; state_n = ST_PASS2; end
        {OP_LSR, ST_PASS2}: begin
          res_lo_n = AluOut; state_n = a_q[ALU_W] ? ST_PASS3 : ST_DONE;
        end
        {OP_LSR, ST_PASS3}: begin res_lo_n = AluOut; state_n = ST_DONE; end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // ALU drive for the pass about to start, registered on the same edge.
  always_comb begin
    alu_a_n = '0;
    alu_b_n = '0;
    fun_n   = FS_IDLE;
    wf_n    = state_n inside {ST_PASS1, ST_PASS2, ST_PASS3, ST_PASS4};
    case ({op_n, state_n})
      {OP_ADD, ST_PASS1}: begin alu_a_n = a_src[ALU_W-1:0]; alu_b_n = b_src[ALU_W-1:0]; fun_n = FS_ADD; end
      {OP_ADD, ST_PASS2}: begin alu_a_n = a_src[WIDTH-1:ALU_W]; alu_b_n = b_src[WIDTH-1:ALU_W]; fun_n = FS_ADD; end
      {OP_ADD, ST_PASS3}: begin alu_a_n = res_hi_n; alu_b_n = 16'h0001; fun_n = FS_ADD; end
      {OP_SUB, ST_PASS1}: begin alu_a_n = a_src[ALU_W-1:0]; alu_b_n = ~b_src[ALU_W-1:0]; fun_n = FS_ADD; end
      {OP_SUB, ST_PASS2}: begin alu_a_n = res_lo_n; alu_b_n = 16'h0001; fun_n = FS_ADD; end
      {OP_SUB, ST_PASS3}: begin alu_a_n = a_src[WIDTH-1:ALU_W]; alu_b_n = ~b_src[WIDTH-1:ALU_W]; fun_n = FS_ADD; end
      {OP_SUB, ST_PASS4}: begin alu_a_n = res_hi_n; alu_b_n = 16'h0001; fun_n = FS_ADD; end
      {OP_AND, ST_PASS1}, {OP_OR, ST_PASS1}, {OP_XOR, ST_PASS1}: begin
        alu_a_n = a_src[ALU_W-1:0]; alu_b_n = b_src[ALU_W-1:0]; fun_n = logic_funsel(op_n);
      end
      {OP_AND, ST_PASS2}, {OP_OR, ST_PASS2}, {OP_XOR, ST_PASS2}: begin
        alu_a_n = a_src[WIDTH-1:ALU_W]; alu_b_n = b_src[WIDTH-1:ALU_W]; fun_n = logic_funsel(op_n);
      end
      {OP_LSL, ST_PASS1}: begin alu_a_n = a_src[ALU_W-1:0]; fun_n = FS_LSL; end
      {OP_LSL, ST_PASS2}: begin alu_a_n = a_src[WIDTH-1:ALU_W]; fun_n = FS_LSL; end
      {OP_LSL, ST_PASS3}: begin alu_a_n = res_hi_n; alu_b_n = 16'h0001; fun_n = FS_OR; end
      {OP_LSR, ST_PASS1}: begin alu_a_n = a_src[WIDTH-1:ALU_W]; fun_n = FS_LSR; end
      {OP_LSR, ST_PASS2}: begin alu_a_n = a_src[ALU_W-1:0]; fun_n = FS_LSR; end
      {OP_LSR, ST_PASS3}: begin alu_a_n = res_lo_n; alu_b_n = 16'h8000; fun_n = FS_OR; end
      default: ;
    endcase
  end

  alu_seq_flags u_flags (
    .op     (op_q),
    .a_msb  (a_q[WIDTH-1]),
    .a_lsb  (a_q[0]),
    .b_msb  (b_q[WIDTH-1]),
    .result ({res_hi_n, res_lo_n}),
    .carry  (c_hi_n),
    .flags  (flags_w)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_lo    <= '0;
      res_hi    <= '0;
      c_lo      <= 1'b0;
      c_hi      <= 1'b0;
      AluA      <= '0;
      AluB      <= '0;
      AluFunSel <= FS_IDLE;
      AluWF     <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      state     <= state_n;
      res_lo    <= res_lo_n;
      res_hi    <= res_hi_n;
      c_lo      <= c_lo_n;
      c_hi      <= c_hi_n;
      AluA      <= alu_a_n;
      AluB      <= alu_b_n;
      AluFunSel <= fun_n;
      AluWF     <= wf_n;
      if (accept) begin
        op_q <= ReqOp;
        a_q  <= ReqA;
        b_q  <= ReqB;
      end
      // Result and flags are loaded on the edge entering DONE and then held.
      if (accept && (ReqOp == OP_RSVD)) begin
        result_q <= '0;
        flags_q  <= '0;
        error_q  <= 1'b1;
      end else if (finish_pass) begin
        result_q <= {res_hi_n, res_lo_n};
        flags_q  <= flags_w;
        error_q  <= 1'b0;
      end
    end
  end

  assign ReqReady = (state == ST_IDLE);
  assign Done     = (state == ST_DONE);
  assign Error    = Done & error_q;
  assign Result   = result_q;
  assign FlagsOut = flags_q;

endmodule
